// File: rtl/mitchell_mul_pipe.sv
// Three-stage pipelined Mitchell logarithmic multiplier on sign-magnitude operands.
// Stage 1: leading-one/log conversion, stage 2: log add, stage 3: antilog into p_o.
module mitchell_mul_pipe #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W:0]   x_i,
  input  logic [W:0]   y_i,
  input  logic         mode_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [2*W:0] p_o
);

  localparam int LAT = 3;
  localparam int KW  = $clog2(W);

  logic [LAT-1:0] vld;
  logic           en;

  assign en          = !out_valid_o || out_ready_i;
  assign in_ready_o  = en && !rst_i;
  assign out_valid_o = vld[LAT-1];

  function automatic logic [KW-1:0] lod(input logic [W-1:0] m);
    lod = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (m[i]) lod = i[KW-1:0];
    end
  endfunction

  // Normalise so the leading one sits at bit W-1; the bits below it are the log fraction.
  function automatic logic [W-2:0] norm(input logic [W-1:0] m, input logic [KW-1:0] k);
    logic [KW-1:0] sh;
    logic [W-1:0]  t;
    sh   = KW'(W-1) - k;
    t    = m << sh;
    norm = t[W-2:0];
  endfunction

  // Stage 1 combinational
  logic [KW-1:0] k_a_n, k_b_n;
  logic [W-2:0]  f_a_n, f_b_n;

  always_comb begin
    k_a_n = lod(x_i[W-1:0]);
    k_b_n = lod(y_i[W-1:0]);
    f_a_n = norm(x_i[W-1:0], k_a_n);
    f_b_n = norm(y_i[W-1:0], k_b_n);
  end

  // Stage 1 registers
  logic [KW-1:0] k1_a, k1_b;
  logic [W-2:0]  f1_a, f1_b;
  logic          z1_a, z1_b, s1_a, s1_b;

  // Stage 2 combinational: log add, fraction carry lands in the characteristic
  logic [KW+W-1:0] sum;

  always_comb begin
    sum = {1'b0, k1_a, f1_a} + {1'b0, k1_b, f1_b};
  end

  // Stage 2 registers
  logic [KW:0]  k2;
  logic [W-2:0] f2;
  logic         z2, s2;

  // Stage 3 combinational: antilog with floor truncation
  logic [3*W-2:0] ext;
  logic [2*W:0]   p_next;

  always_comb begin
    ext    = {{(2*W-1){1'b0}}, 1'b1, f2} << k2;
    p_next = z2 ? '0 : {s2, ext[3*W-2:W-1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld <= '0;
      p_o <= '0;
    end else if (en) begin
      vld <= {vld[LAT-2:0], in_valid_i};
      p_o <= vld[LAT-2] ? p_next : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      k1_a <= k_a_n;
      k1_b <= k_b_n;
      f1_a <= f_a_n;
      f1_b <= f_b_n;
      z1_a <= ~|x_i[W-1:0];
      z1_b <= ~|y_i[W-1:0];
      s1_a <= x_i[W] & mode_i;
      s1_b <= y_i[W] & mode_i;
      k2   <= sum[KW+W-1:W-1];
      f2   <= sum[W-2:0];
      z2   <= z1_a | z1_b;
      s2   <= s1_a ^ s1_b;
    end
  end

endmodule
